// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings plus the small decode helpers used by the RAM responder.
// The master and the SDRAM bridge import the same constants.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B = 3'd0;
    localparam logic [2:0] HSIZE_H = 3'd1;
    localparam logic [2:0] HSIZE_W = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ram_state_e;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_be(input logic [1:0] addr_lo, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            HSIZE_B: be = 4'b0001 << addr_lo;
            HSIZE_H: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_lite_ram_slave_mem.sv
// 32-bit word RAM with per-byte write enables and a registered read port.
// Write and read addresses are separate so a completing write and a new read can share a cycle.
module ahb_lite_ram_slave_mem #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rdata
);

    logic [31:0] mem_q [2**ADDR_BITS];
    logic [31:0] rdata_q;

    // Byte-masked write; read returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite responder on block RAM: programmable wait states, two-cycle ERROR responses,
// and a write-to-read bypass so back-to-back beats at zero wait states never return stale data.
module ahb_lite_ram_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam logic [3:0] WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ram_state_e           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 hreadyout_q, hreadyout_d;
    logic                 hresp_q, hresp_d;
    logic                 dp_valid_q, dp_valid_d;
    logic                 dp_write_q, dp_write_d;
    logic [ADDR_BITS-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]           dp_be_q, dp_be_d;
    logic [3:0]           byp_be_q, byp_be_d;
    logic [31:0]          byp_data_q, byp_data_d;
    logic [31:0]          hold_q, hold_d;

    logic                 accept_s;
    logic                 err_s;
    logic                 complete_s;
    logic                 we_s;
    logic                 re_s;
    logic                 rd_done_s;
    logic [ADDR_BITS-1:0] rd_addr_s;
    logic [31:0]          mem_rdata_s;
    logic [31:0]          merged_s;
    logic                 unused_s;

    function automatic logic addr_err(input logic [31:0] a, input logic [2:0] sz);
        return (a[31:ADDR_BITS+2] != '0) ||
               (sz > HSIZE_W) ||
               ((sz == HSIZE_H) && a[0]) ||
               ((sz == HSIZE_W) && (a[1:0] != 2'b00));
    endfunction

    assign unused_s    = ^{HBURST, HTRANS[0]};
    assign rd_addr_s   = HADDR[ADDR_BITS+1:2];

    // Transfer accept, error classification and data-phase completion strobes.
    always_comb begin
        accept_s   = HSEL & HREADY & HTRANS[1] & hreadyout_q;
        err_s      = addr_err(HADDR, HSIZE);
        complete_s = dp_valid_q & hreadyout_q;
        we_s       = complete_s & dp_write_q;
        rd_done_s  = complete_s & ~dp_write_q;
        re_s       = accept_s & ~err_s & ~HWRITE;
        merged_s   = merge_bytes(mem_rdata_s, byp_data_q, byp_be_q);
    end

    ahb_lite_ram_slave_mem #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk     (HCLK),
        .we      (we_s),
        .be      (dp_be_q),
        .wr_addr (dp_addr_q),
        .wdata   (HWDATA),
        .re      (re_s),
        .rd_addr (rd_addr_s),
        .rdata   (mem_rdata_s)
    );

    // Next-state, data-phase latch, bypass capture and read-data hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_be_d    = dp_be_q;
        byp_be_d   = byp_be_q;
        byp_data_d = byp_data_q;
        hold_d     = hold_q;

        if (complete_s) begin
            dp_valid_d = 1'b0;
        end else begin
            dp_valid_d = dp_valid_q;
        end

        if (rd_done_s) begin
            hold_d = merged_s;
        end else begin
            hold_d = hold_q;
        end

        if (accept_s && !err_s) begin
            dp_valid_d = 1'b1;
            dp_write_d = HWRITE;
            dp_addr_d  = rd_addr_s;
            dp_be_d    = lane_be(HADDR[1:0], HSIZE);
        end else begin
            dp_write_d = dp_write_q;
        end

        // A read landing on the word being written this cycle sees the RAM's old copy.
        if (re_s) begin
            byp_be_d   = (we_s && (dp_addr_q == rd_addr_s)) ? dp_be_q : 4'b0000;
            byp_data_d = HWDATA;
        end else begin
            byp_be_d   = byp_be_q;
        end

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // State and control registers; RAM contents are deliberately left unreset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_addr_q   <= '0;
            dp_be_q     <= 4'b0000;
            byp_be_q    <= 4'b0000;
            byp_data_q  <= 32'h0000_0000;
            hold_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_addr_q   <= dp_addr_d;
            dp_be_q     <= dp_be_d;
            byp_be_q    <= byp_be_d;
            byp_data_q  <= byp_data_d;
            hold_q      <= hold_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rd_done_s ? merged_s : hold_q;

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Directed bench for ahb_lite_ram_slave: one instance with zero wait states, one with three,
// both driven as single-slave buses; expected responses flow through a scoreboard queue.
module tb_ahb_lite_ram_slave;

    logic        hclk;
    logic        hresetn;
    logic [31:0] haddr     [2];
    logic [2:0]  hburst    [2];
    logic        hsel      [2];
    logic [2:0]  hsize     [2];
    logic [1:0]  htrans    [2];
    logic [31:0] hwdata    [2];
    logic        hwrite    [2];
    logic [31:0] hrdata    [2];
    logic        hreadyout [2];
    logic        hresp     [2];

    typedef struct {
        logic [31:0] data;
        logic        resp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model   [2][1024];
    logic [31:0] last_rd [2];
    int          checks;
    int          errors;

    ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr[0]), .HBURST(hburst[0]), .HSEL(hsel[0]),
        .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HWRITE(hwrite[0]),
        .HREADY(hreadyout[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) dut1 (
        .HCLK(hclk), .HRESETn(hresetn), .HADDR(haddr[1]), .HBURST(hburst[1]), .HSEL(hsel[1]),
        .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HWRITE(hwrite[1]),
        .HREADY(hreadyout[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [3:0] be_f(input logic [31:0] a, input logic [2:0] sz);
        logic [3:0] one;
        one = 4'b0001;
        if (sz == 3'd0) return one << a[1:0];
        if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic err_f(input logic [31:0] a, input logic [2:0] sz);
        return (a[31:12] != 20'd0) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwrite[d] = 1'b0;
    endtask

    // Expected outcome of an address phase, with the model updated for OKAY writes.
    task automatic expect_xfer(input int d, input logic wr, input logic [2:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
        exp_t       e;
        logic [3:0] be;
        if (err_f(a, sz)) begin
            e.resp = 1'b1;
            e.data = last_rd[d];
        end else begin
            e.resp = 1'b0;
            if (wr) begin
                be = be_f(a, sz);
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[d][a[11:2]][8*i +: 8] = wd[8*i +: 8];
                e.data = last_rd[d];
            end else begin
                e.data     = model[d][a[11:2]];
                last_rd[d] = e.data;
            end
        end
        sb.push_back(e);
    endtask

    // One non-pipelined transfer; waits counts HREADYOUT-low data-phase cycles.
    task automatic xfer(input int d, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_waits, input string tag);
        exp_t e;
        int   waits;
        logic first_resp;
        @(posedge hclk); #1;
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hsize[d] = sz; hwrite[d] = wr;
        expect_xfer(d, wr, sz, a, wd);
        @(posedge hclk); #1;
        bus_idle(d);
        hwdata[d]  = wd;
        waits      = 0;
        first_resp = 1'b0;
        @(negedge hclk);
        while (!hreadyout[d] && waits < 20) begin
            if (waits == 0) first_resp = hresp[d];
            waits++;
            @(negedge hclk);
        end
        e = sb.pop_front();
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        if (exp_waits > 0) check({tag, "_wresp"}, {31'd0, first_resp}, {31'd0, e.resp});
        check({tag, "_resp"}, {31'd0, hresp[d]}, {31'd0, e.resp});
        check({tag, "_rdata"}, hrdata[d], e.data);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            haddr[d] = 32'd0; hburst[d] = 3'd0; hsize[d] = 3'd2; hwdata[d] = 32'd0;
            last_rd[d] = 32'd0;
            for (int w = 0; w < 1024; w++) model[d][w] = 32'd0;
        end
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", {31'd0, hreadyout[d]}, 32'd1);
            check("rst_resp", {31'd0, hresp[d]}, 32'd0);
            check("rst_rdata", hrdata[d], 32'd0);
        end
        hresetn = 1'b1;

        // Zero-wait write then read of the same word on consecutive cycles.
        @(posedge hclk); #1;
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h10; hsize[0] = 3'd2; hwrite[0] = 1'b1;
        expect_xfer(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        void'(sb.pop_front());
        @(posedge hclk); #1;
        hwdata[0] = 32'hDEADBEEF;
        htrans[0] = 2'b11; haddr[0] = 32'h10; hwrite[0] = 1'b0;
        expect_xfer(0, 1'b0, 3'd2, 32'h10, 32'd0);
        @(negedge hclk);
        check("b2b_wr_ready", {31'd0, hreadyout[0]}, 32'd1);
        @(posedge hclk); #1;
        bus_idle(0);
        @(negedge hclk);
        e = sb.pop_front();
        check("b2b_rd_ready", {31'd0, hreadyout[0]}, 32'd1);
        check("b2b_rd_resp", {31'd0, hresp[0]}, {31'd0, e.resp});
        check("b2b_rd_data", hrdata[0], e.data);
        @(negedge hclk);
        check("b2b_rd_hold", hrdata[0], 32'hDEADBEEF);

        // Three wait states on the second instance.
        xfer(1, 1'b1, 3'd2, 32'h0, 32'hCAFE0001, 3, "ws3_wr");
        xfer(1, 1'b0, 3'd2, 32'h0, 32'h0, 3, "ws3_rd");

        // Byte and halfword lanes merged into one word.
        xfer(0, 1'b1, 3'd2, 32'h20, 32'h00000000, 0, "lane_clr");
        xfer(0, 1'b1, 3'd0, 32'h21, 32'h0000AA00, 0, "lane_b");
        xfer(0, 1'b1, 3'd1, 32'h22, 32'h12340000, 0, "lane_h");
        xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, "lane_rd");
        check("lane_word", hrdata[0], 32'h1234AA00);

        // Out-of-range address: two-cycle ERROR, no RAM side effect.
        xfer(0, 1'b1, 3'd2, 32'h0, 32'h11111111, 0, "oor_init");
        xfer(0, 1'b0, 3'd2, 32'h1000, 32'h0, 1, "oor_rd");
        xfer(0, 1'b1, 3'd2, 32'h1000, 32'h99999999, 1, "oor_wr");
        xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, 0, "oor_word0");
        xfer(1, 1'b0, 3'd2, 32'h1000, 32'h0, 1, "oor_ws3");

        // Misaligned and oversized transfers.
        xfer(0, 1'b1, 3'd2, 32'h4, 32'h44444444, 0, "mis_init");
        xfer(0, 1'b1, 3'd2, 32'h6, 32'hEEEEEEEE, 1, "mis_w");
        xfer(0, 1'b1, 3'd1, 32'h5, 32'hEEEEEEEE, 1, "mis_h");
        xfer(0, 1'b1, 3'd3, 32'h4, 32'hEEEEEEEE, 1, "mis_sz");
        xfer(0, 1'b0, 3'd2, 32'h4, 32'h0, 0, "mis_rd");

        // Reset during the wait states of a write.
        xfer(1, 1'b1, 3'd2, 32'h8, 32'h55AA55AA, 3, "rst_pre");
        xfer(1, 1'b0, 3'd2, 32'h8, 32'h0, 3, "rst_prerd");
        @(posedge hclk); #1;
        hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h8; hsize[1] = 3'd2; hwrite[1] = 1'b1;
        @(posedge hclk); #1;
        bus_idle(1);
        hwdata[1] = 32'hFFFFFFFF;
        @(negedge hclk);
        check("mid_wait", {31'd0, hreadyout[1]}, 32'd0);
        #1 hresetn = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, hreadyout[1]}, 32'd1);
        check("mid_rst_resp", {31'd0, hresp[1]}, 32'd0);
        check("mid_rst_rdata", hrdata[1], 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        xfer(1, 1'b0, 3'd2, 32'h8, 32'h0, 3, "rst_post");

        repeat (2) @(negedge hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
